// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch control slice.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    JMP  = 2'b01,
    BR   = 2'b10
  } redir_t;

  localparam int unsigned DEF_MAX_WAIT = 16;

endpackage

// File: rtl/fetch_wait_cnt.sv
// Wait counter with synchronous clear/enable; tc flags the last cycle before the limit.
module fetch_wait_cnt #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  // tc is asserted on the cycle whose increment would reach MAX_WAIT
  assign tc = (cnt == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: imem request/response handshake, one-entry decode buffer,
// redirect handling and next-PC control for the PC/incr4/branch/jump datapath.
import fetch_pkg::*;

module fetch_ctrl #(
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_req,
  input  logic        jmp_req,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic        pc_wr_en,
  output logic        branch_sel,
  output logic        jmp_sel,
  output logic        busy,
  output logic        timeout_err
);

  state_t           state;
  redir_t           redir, redir_nxt;
  logic             flush;
  logic             live, redir_in, hs, tc;
  logic [CNT_W-1:0] cnt;

  fetch_wait_cnt #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (hs),
    .en    (state == WAIT),
    .cnt   (cnt),
    .tc    (tc)
  );

  // pc_wr_en and selects are combinational so the PC is already updated
  // by the time the next request is issued from REQ.
  always_comb begin
    live      = (state == REQ) || (state == WAIT) || (state == HOLD);
    redir_in  = live && (branch_req || jmp_req);
    redir_nxt = redir;
    if (live && branch_req)                        redir_nxt = BR;
    else if (live && jmp_req && (redir == NONE))   redir_nxt = JMP;
    imem_req_valid = (state == REQ) && !stall;
    hs             = imem_req_valid && imem_req_ready;
    pc_wr_en       = 1'b0;
    if ((state == WAIT) && imem_rsp_valid && (flush || redir_in)) pc_wr_en = 1'b1;
    if ((state == HOLD) && ((inst_valid && inst_ready) || (redir_nxt != NONE)))
      pc_wr_en = 1'b1;
    branch_sel = pc_wr_en && (redir_nxt == BR);
    jmp_sel    = pc_wr_en && (redir_nxt == JMP);
    busy       = live;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      redir       <= NONE;
      flush       <= 1'b0;
      inst_valid  <= 1'b0;
      inst_data   <= '0;
      timeout_err <= 1'b0;
    end else begin
      redir <= redir_nxt;
      // a redirect before the response arrives makes the in-flight fetch stale
      if (((state == REQ) || (state == WAIT)) && redir_in) flush <= 1'b1;
      case (state)
        IDLE: if (start) state <= REQ;
        REQ:  if (hs) state <= WAIT;
        WAIT: begin
          if (imem_rsp_valid) begin
            if (flush || redir_in) begin
              redir <= NONE;
              flush <= 1'b0;
              state <= REQ;
            end else begin
              inst_data  <= imem_rsp_data;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end else if (tc) begin
            timeout_err <= 1'b1;
            state       <= ERR;
          end
        end
        HOLD: begin
          if (pc_wr_en) begin
            inst_valid <= 1'b0;
            redir      <= NONE;
            state      <= REQ;
          end
        end
        ERR:     timeout_err <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (MAX_WAIT overridden to 4).
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, stall, branch_req, jmp_req;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data;
  logic        pc_wr_en, branch_sel, jmp_sel, busy, timeout_err;

  int checks   = 0;
  int failures = 0;

  fetch_ctrl #(.MAX_WAIT(4), .CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stall          (stall),
    .branch_req     (branch_req),
    .jmp_req        (jmp_req),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .pc_wr_en       (pc_wr_en),
    .branch_sel     (branch_sel),
    .jmp_sel        (jmp_sel),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; outputs are sampled 2 units later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b1; stall = 1'b0; branch_req = 1'b0; jmp_req = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b1;
    tick(); tick(); tick();
    settle();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_data", inst_data, 0);
    check("rst_pc_wr_en", pc_wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_err, 0);

    // basic fetch
    reset = 1'b1; start = 1'b0;
    tick(); settle();
    check("idle_busy", busy, 0);
    start = 1'b1;
    tick(); start = 1'b0; settle();
    check("req_valid", imem_req_valid, 1);
    check("req_busy", busy, 1);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h8C220004; settle();
    check("wait_pc_wr_en", pc_wr_en, 0);
    tick();
    imem_rsp_valid = 1'b0; settle();
    check("hold_inst_valid", inst_valid, 1);
    check("hold_inst_data", inst_data, 32'h8C220004);
    check("hold_pc_wr_en", pc_wr_en, 1);
    check("hold_branch_sel", branch_sel, 0);
    check("hold_jmp_sel", jmp_sel, 0);
    check("hold_req_valid", imem_req_valid, 0);
    tick(); settle();
    check("next_inst_valid", inst_valid, 0);
    check("next_pc_wr_en", pc_wr_en, 0);
    check("next_req_valid", imem_req_valid, 1);

    // jump during WAIT flushes the late response
    tick();
    jmp_req = 1'b1; settle();
    check("jw_pc_wr_en_early", pc_wr_en, 0);
    tick();
    jmp_req = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF; settle();
    check("jw_pc_wr_en", pc_wr_en, 1);
    check("jw_jmp_sel", jmp_sel, 1);
    check("jw_branch_sel", branch_sel, 0);
    tick();
    imem_rsp_valid = 1'b0; settle();
    check("jw_inst_valid", inst_valid, 0);
    check("jw_req_valid", imem_req_valid, 1);
    check("jw_pc_wr_en_after", pc_wr_en, 0);

    // branch and jump together in HOLD
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h11112222;
    tick();
    imem_rsp_valid = 1'b0; inst_ready = 1'b0; settle();
    check("bh_inst_valid", inst_valid, 1);
    check("bh_pc_wr_en_idle", pc_wr_en, 0);
    branch_req = 1'b1; jmp_req = 1'b1; settle();
    check("bh_pc_wr_en", pc_wr_en, 1);
    check("bh_branch_sel", branch_sel, 1);
    check("bh_jmp_sel", jmp_sel, 0);
    tick();
    branch_req = 1'b0; jmp_req = 1'b0; settle();
    check("bh_inst_valid_after", inst_valid, 0);
    check("bh_pc_wr_en_after", pc_wr_en, 0);
    check("bh_req_valid", imem_req_valid, 1);

    // branch in the same cycle as the response: response dropped
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h33334444; branch_req = 1'b1; settle();
    check("br_rsp_pc_wr_en", pc_wr_en, 1);
    check("br_rsp_branch_sel", branch_sel, 1);
    tick();
    imem_rsp_valid = 1'b0; branch_req = 1'b0; settle();
    check("br_rsp_inst_valid", inst_valid, 0);
    check("br_rsp_req_valid", imem_req_valid, 1);

    // stall in REQ, then stall in WAIT does not block the response
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("stall_req_valid", imem_req_valid, 0);
      tick();
    end
    stall = 1'b0; settle();
    check("unstall_req_valid", imem_req_valid, 1);
    tick();
    stall = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFEF00D;
    tick();
    imem_rsp_valid = 1'b0; stall = 1'b0; inst_ready = 1'b0; settle();
    check("stallw_inst_valid", inst_valid, 1);
    check("stallw_inst_data", inst_data, 32'hCAFEF00D);

    // decode back-pressure in HOLD, then reset mid-HOLD
    for (int i = 0; i < 10; i++) begin
      settle();
      check("bp_inst_valid", inst_valid, 1);
      check("bp_inst_data", inst_data, 32'hCAFEF00D);
      check("bp_pc_wr_en", pc_wr_en, 0);
      check("bp_req_valid", imem_req_valid, 0);
      tick();
    end
    reset = 1'b0;
    tick(); settle();
    check("hrst_inst_valid", inst_valid, 0);
    check("hrst_inst_data", inst_data, 0);
    check("hrst_busy", busy, 0);
    check("hrst_pc_wr_en", pc_wr_en, 0);
    reset = 1'b1; inst_ready = 1'b1;

    // timeout after 4 WAIT cycles with no response
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      settle();
      check("to_wait_err", timeout_err, 0);
      check("to_wait_busy", busy, 1);
      tick();
    end
    settle();
    check("to_err", timeout_err, 1);
    check("to_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      tick();
      start = 1'b0; settle();
      check("to_sticky", timeout_err, 1);
      check("to_no_req", imem_req_valid, 0);
    end
    reset = 1'b0;
    tick(); settle();
    check("to_cleared", timeout_err, 0);
    reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
